dm_access_ctrl: RTL and testbench
=================================

# dm_access_ctrl

Initiator-side controller that sits between the multi-cycle datapath and the byte-addressed, word-wide data memory. The data memory has a combinational 32-bit little-endian read and a posedge-clocked write that always updates all four bytes. This block turns the datapath's load and store requests (byte, halfword and word; signed or unsigned) into legal memory cycles. Sub-word stores are performed as a read-modify-write sequence, and every access is alignment-checked.

## Interface
Parameters:
- AW, 10, memory byte-address width.
- DW, 32, data width; fixed at 32 and not otherwise supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  1  start an access; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
- sext  in  1  sign-extend a sub-word load; ignored for stores and words.
- addr  in  AW  byte address from the ALU.
- wdata  in  32  store data; the sub-word is taken from its low bits.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid while done=1, 0 otherwise.
- rdata  out  32  load result; holds until the next successful load completes.
- dm_addr  out  AW  word-aligned memory address, {addr[AW-1:2],2'b00}.
- dm_din  out  32  memory write data.
- dm_wr  out  1  memory write enable.
- dm_dout  in  32  memory read data (combinational).

## Operation
- States: IDLE, READ, WRITE, DONE.
- Latching: on req in IDLE, latch we, size, sext, addr[1:0], the aligned address and wdata. Later changes to the inputs have no effect on the access in flight.
- Alignment check at acceptance:
  - A halfword needs addr[0]=0.
  - A word needs addr[1:0]=00.
  - size=11 is always an error.
  - On error go straight to DONE with err=1. There is no memory write and rdata is unchanged.
- Load: IDLE→READ→DONE. In READ, capture dm_dout into the internal word register at the clock edge.
- Word store: IDLE→WRITE→DONE. In WRITE, dm_din = wdata and dm_wr = 1.
- Sub-word store: IDLE→READ→WRITE→DONE. In READ, capture the current word. In WRITE, dm_din is that word with the target lane replaced:
  - byte k: bits [8k+7:8k] ← wdata[7:0];
  - halfword at offset 0 → [15:0], at offset 2 → [31:16], from wdata[15:0].
- Load extraction: select the same lanes from the captured word. Zero-extend, or sign-extend from bit 7/15 when sext=1. Register the result into rdata on the edge entering DONE.
- DONE → IDLE unconditionally after one cycle.
- req is ignored whenever busy=1. No queuing.
- dm_wr is decoded only from state==WRITE, so it is never high in any other state.

## Timing
- Let E0 be the accepting edge.
- Load: READ in E0–E1, done=1 in E1–E2, rdata valid from E1.
- Word store: dm_wr high in E0–E1, memory updated at E1, done in E1–E2.
- Sub-word store: READ in E0–E1, WRITE in E1–E2 (memory updated at E2), done in E2–E3.
- Misaligned access: done=1, err=1 in E0–E1.
- A new req may be accepted in the IDLE cycle that follows DONE. There is no back-to-back acceptance from DONE.
- Reset values: state IDLE; busy, done, err, dm_wr = 0; rdata, dm_addr, dm_din = 0.
- Reset asserted mid-access forces IDLE immediately and drops dm_wr asynchronously. If reset arrives during READ of an RMW, no write occurs. The access is lost and no done is issued.

## Test plan
- sw 0xDEADBEEF to address 0x010, then lw from 0x010 → dm_wr for exactly one cycle; done at E1 for each access; rdata=0xDEADBEEF.
- After the word above, sb 0x55 to 0x012 → dm_wr is seen only in the WRITE cycle; the following lw returns 0xDE55BEEF. Total latency to done is 2 cycles.
- lh sext=1 at 0x012 on word 0x8001_1234 → rdata=0xFFFF8001. lbu at 0x011 → 0x00000012.
- lw at 0x013, and separately sh at 0x001 → done=1 and err=1 at E0+1, no dm_wr, rdata unchanged. size=11 gives the same result.
- Pulse rst during the READ state of an sb → busy=0 and dm_wr=0 immediately, and the memory word is unchanged.
- Hold req high continuously with changing addr → the request is accepted only from IDLE; the first access completes with its latched address, and the next one starts one cycle after done.

Source files
------------

// File: rtl/dm_access_ctrl.sv
// Load/store controller for a word-wide, byte-addressed data memory.
// Sub-word stores use read-modify-write; every access is alignment-checked.
module dm_access_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic          we,
  input  logic [1:0]    size,
  input  logic          sext,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_din,
  output logic          dm_wr,
  input  logic [DW-1:0] dm_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sext_q, sext_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] word_q, word_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          misalign;
  logic [DW-1:0] shifted, extracted, merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      off_q   <= 2'b00;
      waddr_q <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      off_q   <= off_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    misalign = (size == 2'b11) ||
               (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);
  end

  // Load lane extraction straight from dm_dout so rdata lands on the edge entering DONE.
  always_comb begin
    shifted   = dm_dout >> {off_q, 3'b000};
    extracted = dm_dout;
    case (size_q)
      2'b00:   extracted = {{24{sext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   extracted = {{16{sext_q & shifted[15]}}, shifted[15:0]};
      default: extracted = dm_dout;
    endcase
  end

  always_comb begin
    merged = word_q;
    case (size_q)
      2'b00:   merged[{off_q, 3'b000} +: 8]        = wdata_q[7:0];
      2'b01:   merged[{off_q[1], 4'b0000} +: 16]   = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    off_d   = off_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d    = we;
          size_d  = size;
          sext_d  = sext;
          off_d   = addr[1:0];
          waddr_d = {addr[AW-1:2], 2'b00};
          wdata_d = wdata;
          err_d   = misalign;
          if (misalign)                 state_d = DONE;
          else if (we && size == 2'b10) state_d = WRITE;
          else                          state_d = READ;
        end
      end
      READ: begin
        word_d = dm_dout;
        if (we_q) begin
          state_d = WRITE;
        end else begin
          rdata_d = extracted;
          state_d = DONE;
        end
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    err     = done & err_q;
    dm_wr   = (state_q == WRITE);
    dm_din  = dm_wr ? merged : '0;
    dm_addr = waddr_q;
    rdata   = rdata_q;
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomized bench for dm_access_ctrl against a byte-array memory reference model.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, sext;
  logic [1:0]  size;
  logic [9:0]  addr;
  logic [31:0] wdata;
  logic        busy, done, err, dm_wr;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [9:0]  dm_addr;

  logic [31:0] mem [0:255];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] ref_rdata;
  logic        load_mem;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dm_access_ctrl #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
    .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_wr(dm_wr),
    .dm_dout(dm_dout)
  );

  function automatic logic [31:0] ref_word(int w);
    return {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
  endfunction

  function automatic logic [31:0] ref_load(logic [9:0] a, logic [1:0] sz, logic sx);
    int n = 1 << sz;
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(a) + i];
    if (sx && n < 4 && v[8*n-1])
      for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  // Environment memory: clocked write, combinational read.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_word(i);
    end else if (dm_wr) begin
      mem[dm_addr[9:2]] <= dm_din;
    end
  end
  assign dm_dout = mem[dm_addr[9:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic access(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [9:0] a, input logic [31:0] wd, input string tag);
    logic mis;
    int   lat, n, wrs, nb;
    mis = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    lat = mis ? 1 : (!w ? 2 : (sz == 2'b10 ? 2 : 3));
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sext = sx; addr = a; wdata = wd;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; addr = ~a; wdata = ~wd; size = ~sz;
    n = 1; wrs = 0;
    while (n <= 10) begin
      if (dm_wr) wrs++;
      if (done) break;
      @(negedge clk);
      n++;
    end
    if (!mis) begin
      nb = 1 << sz;
      if (w) for (int i = 0; i < nb; i++) ref_mem[int'(a) + i] = wd[8*i +: 8];
      else   ref_rdata = ref_load(a, sz, sx);
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_err"}, err, mis);
    chk({tag, "_wrs"}, wrs, (w && !mis) ? 1 : 0);
    chk({tag, "_rdata"}, rdata, ref_rdata);
    chk({tag, "_mem"}, mem[a[9:2]], ref_word(int'(a[9:2])));
  endtask

  initial begin
    logic [9:0] a, c;
    logic [1:0] sz;
    req = 0; we = 0; size = 0; sext = 0; addr = 0; wdata = 0;
    rst = 1'b1; load_mem = 1'b1; ref_rdata = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    load_mem = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_wr", dm_wr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_addr", dm_addr, 0);
    chk("rst_din", dm_din, 0);
    rst = 1'b0;

    access(1, 2'b10, 0, 10'h010, 32'hDEADBEEF, "sw");
    access(0, 2'b10, 0, 10'h010, 32'h0, "lw");
    chk("lw_val", rdata, 32'hDEADBEEF);
    access(1, 2'b00, 0, 10'h012, 32'h55, "sb");
    access(0, 2'b10, 0, 10'h010, 32'h0, "lw2");
    chk("lw2_val", rdata, 32'hDE55BEEF);
    access(1, 2'b10, 0, 10'h010, 32'h80011234, "sw2");
    access(0, 2'b01, 1, 10'h012, 32'h0, "lh");
    chk("lh_val", rdata, 32'hFFFF8001);
    access(0, 2'b00, 0, 10'h011, 32'h0, "lbu");
    chk("lbu_val", rdata, 32'h00000012);
    access(0, 2'b10, 0, 10'h013, 32'h0, "lw_mis");
    access(1, 2'b01, 0, 10'h001, 32'hFFFF, "sh_mis");
    access(0, 2'b11, 0, 10'h010, 32'h0, "sz3");
    chk("mis_rdata", rdata, 32'h00000012);

    // Reset during the READ of a byte store: no write, no done.
    @(negedge clk);
    req = 1; we = 1; size = 2'b00; sext = 0; addr = 10'h021; wdata = 32'hA5;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    chk("rmw_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_wr", dm_wr, 0);
    @(negedge clk);
    rst = 1'b0;
    ref_rdata = '0;
    @(negedge clk);
    chk("arst_done", done, 0);
    chk("arst_mem", mem[8], ref_word(8));

    // req held high while addr keeps moving.
    a = 10'h040; c = 10'h0C8;
    @(negedge clk);
    req = 1; we = 0; size = 2'b10; sext = 0; addr = a;
    @(posedge clk);
    @(negedge clk);
    addr = 10'h100;
    @(negedge clk);
    ref_rdata = ref_load(a, 2'b10, 0);
    chk("hold_done", done, 1);
    chk("hold_rdata", rdata, ref_rdata);
    addr = c;
    @(negedge clk);
    chk("hold_idle", busy, 0);
    @(negedge clk);
    chk("hold_busy2", busy, 1);
    chk("hold_addr2", dm_addr, c);
    req = 0;
    @(negedge clk);
    ref_rdata = ref_load(c, 2'b10, 0);
    chk("hold_done2", done, 1);
    chk("hold_rdata2", rdata, ref_rdata);

    for (int k = 0; k < 200; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = 10'($urandom);
      if ($urandom_range(0, 3) != 0 && sz != 2'b11) a = a & ~((10'd1 << sz) - 10'd1);
      access(1'($urandom), sz, 1'($urandom), a, $urandom, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
